mac_array_seq_ctrl: RTL and testbench
=====================================

Name: mac_array_seq_ctrl

Overview:
- Sequencer for the vectored MAC/FIFO datapath: a DATA_WIDTH x DATA_WIDTH MAC array fed by DATA_WIDTH per-row operand FIFOs.
- On start, it clears the MACs and streams DATA_WIDTH*DATA_WIDTH bytes from memory into the FIFOs, one FIFO per row.
- It then pops the FIFOs with a systolic skew while enabling the MACs, and flags completion.
- Sits between the memory read port and the vectored_mac_fifo datapath and drives all of that datapath's control pins.

Parameters:
DATA_WIDTH, 8, array dimension: number of FIFOs, entries per FIFO, MAC rows and columns.
ADDR_W, 6, memory beat address width; must be at least log2(DATA_WIDTH*DATA_WIDTH).

Ports:
clk  input  1  single clock, all state rising-edge.
rst  input  1  asynchronous active-high reset.
start  input  1  one-cycle request to run one tile; honoured only in IDLE.
abort  input  1  synchronous abort; return to IDLE from any state.
mem_valid  input  1  memory beat valid this cycle; ignored unless mem_req is high.
full  input  DATA_WIDTH  per-FIFO full flags.
empty  input  DATA_WIDTH  per-FIFO empty flags.
mem_req  output  1  request/ready for memory beats.
mem_addr  output  ADDR_W  address of the beat currently requested: {row, col}.
wren  output  DATA_WIDTH  one-hot FIFO write enable, combinational from mem_valid and the row index.
rden  output  DATA_WIDTH  skewed FIFO read enables.
mac_en  output  1  MAC array enable.
mac_clr  output  1  MAC accumulator clear pulse.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle completion pulse.
underflow  output  1  sticky error flag; cleared by rst or by an accepted start.

Behaviour:
- Reset values: state=IDLE; mem_addr, beat count and run count = 0; all outputs 0, including underflow.
- State IDLE: start=1 -> CLEAR and clear underflow. A start pulse while busy is ignored.
- State CLEAR: lasts 1 cycle with mac_clr=1; then go to FILL with mem_addr=0.
- State FILL, requesting: mem_req=1 while beat count < DATA_WIDTH*DATA_WIDTH.
- State FILL, beat accept: on mem_valid & mem_req, wren[row]=1 where row = mem_addr / DATA_WIDTH; mem_addr and beat count then increment.
- State FILL, completion: after the final beat, mem_req=0. Stay in FILL until &full==1 (full may lag the last write by one cycle), then go to RUN with run count=0.
- FILL stall: a FIFO that never reports full stalls FILL indefinitely; abort is the recovery path.
- State RUN: lasts exactly 3*DATA_WIDTH-2 cycles, t = 0 .. 3*DATA_WIDTH-3.
  - mac_en=1 on every RUN cycle.
  - rden[k]=1 iff k <= t < k+DATA_WIDTH, so row k begins popping k cycles after row 0 and each FIFO is popped exactly DATA_WIDTH times.
  - On the last RUN cycle, go to DONE.
- State DONE: done=1 and busy=1 for 1 cycle, then IDLE.
- Underflow detection: any cycle with rden[k] & empty[k] sets underflow. The pop is still issued; the sequence is not altered.
- Write guard: wren is never asserted outside FILL, even if mem_valid is high.
- abort, any state:
  - Next cycle the state is IDLE and mem_req, wren, rden and mac_en drop immediately (combinational from state).
  - A 1-cycle mac_clr is issued on the cycle after abort.
  - done does not pulse.
  - FIFO contents are not flushed by this block.
- Simultaneous abort and start in IDLE: abort wins and start is dropped.
- rst asserted mid-operation: immediate return to reset values, with no mac_clr pulse.
- Width rules: beat count is log2(DATA_WIDTH*DATA_WIDTH)+1 bits and saturates at DATA_WIDTH*DATA_WIDTH. Run count is log2(3*DATA_WIDTH)+1 bits. mem_addr does not wrap within a tile.
- Latency with zero-wait memory: start -> done = 1 (CLEAR) + DATA_WIDTH^2 (FILL beats) + 0/1 (full lag) + 3*DATA_WIDTH-2 (RUN) + 1 cycles.

Test Plan:
- DATA_WIDTH=4, mem_valid tied 1, FIFO model reports full one cycle after the 4th write: start -> mac_clr at cycle 1; wren one-hot rows 0,0,0,0,1,...,3 with mem_addr 0..15; 10 RUN cycles; done exactly once; busy returns low.
- RUN skew check, same setup: rden[0] high on t=0..3 and rden[3] high on t=3..6; each rden bit asserted exactly 4 times; mac_en high for 10 consecutive cycles.
- Memory stalls with mem_valid randomly 50%: exactly 16 writes, mem_addr increments only on accepted beats, and the RUN profile is unchanged.
- abort asserted at beat 7 of FILL: next cycle state IDLE, mem_req=0, mac_clr=1 for one cycle, no done. A subsequent start restarts at mem_addr=0.
- Underflow: hold empty[2]=1 during RUN -> underflow set at t=2 and held through IDLE. The next accepted start clears it.
- start pulsed during FILL and RUN -> ignored, no restart, single done. Async rst mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/mac_array_seq_ctrl.sv
// mac_array_seq_ctrl: sequencer for the vectored MAC/FIFO datapath.
// Clears the MAC array, streams DATA_WIDTH*DATA_WIDTH memory beats into the
// per-row operand FIFOs, then pops them with a systolic skew while the MACs
// accumulate, and finally pulses done.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; all datapath controls low
// S_CLEAR | one-cycle MAC accumulator clear
// S_FILL  | request beats and write them into FIFO row mem_addr/DATA_WIDTH
// S_RUN   | 3*DATA_WIDTH-2 cycles of skewed FIFO pops with MACs enabled
// S_DONE  | one-cycle completion pulse
module mac_array_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] full,
  input  logic [DATA_WIDTH-1:0] empty,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] wren,
  output logic [DATA_WIDTH-1:0] rden,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  busy,
  output logic                  done,
  output logic                  underflow
);

  localparam int NBEATS  = DATA_WIDTH * DATA_WIDTH;
  localparam int BEAT_W  = $clog2(NBEATS) + 1;
  localparam int RUN_LEN = 3 * DATA_WIDTH - 2;
  localparam int RUN_W   = $clog2(3 * DATA_WIDTH) + 1;

  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(NBEATS);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_LEN - 1);
  localparam logic [ADDR_W-1:0] ROW_DIV   = ADDR_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FILL  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [RUN_W-1:0]    run_cnt;
  logic                abort_clr;
  logic                accept;
  logic                start_ok;
  logic                fill_done;
  logic [ADDR_W-1:0]   row_idx;

  assign accept    = mem_req & mem_valid;
  assign start_ok  = (state == S_IDLE) & start & ~abort;
  assign fill_done = (beat_cnt == BEAT_MAX) & (&full);
  assign row_idx   = mem_addr / ROW_DIV;

  // State register; abort_clr remembers an abort so mac_clr fires one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      abort_clr <= 1'b0;
    end else begin
      state     <= state_nxt;
      abort_clr <= abort;
    end
  end

  // Next-state logic; abort overrides everything, including a start in IDLE.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start) state_nxt = S_CLEAR;
        S_CLEAR: state_nxt = S_FILL;
        S_FILL:  if (fill_done) state_nxt = S_RUN;
        S_RUN:   if (run_cnt == RUN_LAST) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Beat address/count and RUN timer. mem_addr holds on the final beat so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= '0;
      beat_cnt <= '0;
      run_cnt  <= '0;
    end else begin
      if (state == S_CLEAR) begin
        mem_addr <= '0;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (beat_cnt != BEAT_LAST) mem_addr <= mem_addr + 1'b1;
      end
      if (state == S_RUN) run_cnt <= run_cnt + 1'b1;
      else                run_cnt <= '0;
    end
  end

  // Sticky underflow: cleared by an accepted start, set by any pop of an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  underflow <= 1'b0;
    else if (start_ok)        underflow <= 1'b0;
    else if (|(rden & empty)) underflow <= 1'b1;
  end

  // Outputs decoded from state; wren/rden fan out per FIFO row.
  always_comb begin
    mem_req = (state == S_FILL) && (beat_cnt < BEAT_MAX);
    mac_en  = (state == S_RUN);
    mac_clr = (state == S_CLEAR) || abort_clr;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    wren    = '0;
    rden    = '0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      wren[k] = mem_req && mem_valid && (row_idx == ADDR_W'(k));
      rden[k] = (state == S_RUN) && (run_cnt >= RUN_W'(k)) &&
                (run_cnt < RUN_W'(k + DATA_WIDTH));
    end
  end

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Bench for mac_array_seq_ctrl at DATA_WIDTH=4 with a counting FIFO model
// whose full flag follows the entry count combinationally.
module tb_mac_array_seq_ctrl;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int RUNL = 3 * N - 2;

  logic          clk = 0;
  logic          rst = 1;
  logic          start = 0, abort = 0, mem_valid = 0;
  logic [N-1:0]  full, empty;
  logic          mem_req, mac_en, mac_clr, busy, done, underflow;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  wren, rden;

  logic [N-1:0]  force_empty = '0;
  logic          flush = 0;
  int            cnt [N];

  int checks = 0;
  int errors = 0;

  mac_array_seq_ctrl #(.DATA_WIDTH(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_valid(mem_valid),
    .full(full), .empty(empty), .mem_req(mem_req), .mem_addr(mem_addr),
    .wren(wren), .rden(rden), .mac_en(mac_en), .mac_clr(mac_clr),
    .busy(busy), .done(done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // FIFO occupancy model
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) cnt[k] <= 0;
    end else if (flush) begin
      for (int k = 0; k < N; k++) cnt[k] <= 0;
    end else begin
      for (int k = 0; k < N; k++)
        cnt[k] <= cnt[k] + (wren[k] ? 1 : 0) - ((rden[k] && cnt[k] > 0) ? 1 : 0);
    end
  end

  always_comb begin
    full  = '0;
    empty = '0;
    for (int k = 0; k < N; k++) begin
      full[k]  = (cnt[k] >= N);
      empty[k] = (cnt[k] == 0) || force_empty[k];
    end
  end

  // observations of one tile
  int           n_wr, last_wr, addr_bad, wren_bad, clr_n, clr_first;
  int           run_start, run_last, run_len, done_n, done_cyc, abort_cyc;
  int           rd_cnt [N];
  logic [N-1:0] wr_vec [N*N];
  int           wr_addr [N*N];
  logic [N-1:0] rd_log [16];
  logic         uf_log [16];
  logic [5:0]   post_abort;
  logic         clr2, uf_c1, busy_after, timeout;

  task automatic run_tile(input int pct, input int abort_beat, input bit spam);
    bit finished = 0;
    logic last_busy = 1, last_done = 0;
    n_wr = 0; last_wr = -1; addr_bad = 0; wren_bad = 0; clr_n = 0; clr_first = -1;
    run_start = -1; run_last = -1; run_len = 0; done_n = 0; done_cyc = -1;
    abort_cyc = -1; post_abort = '1; clr2 = 1; uf_c1 = 1; busy_after = 1;
    for (int k = 0; k < N; k++) rd_cnt[k] = 0;
    for (int t = 0; t < 16; t++) begin rd_log[t] = '0; uf_log[t] = 0; end
    for (int j = 0; j < N*N; j++) begin wr_vec[j] = '0; wr_addr[j] = -1; end
    @(posedge clk); #1;
    start = 1; abort = 0; mem_valid = ($urandom_range(99) < pct);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      start = spam && last_busy && !last_done && ($urandom_range(3) == 0);
      abort = 0;
      if (abort_beat >= 0 && abort_cyc < 0 && n_wr == abort_beat) begin
        abort = 1; abort_cyc = i;
      end
      mem_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      if (mem_req && int'(mem_addr) != n_wr) addr_bad++;
      if (wren != 0 && !(mem_req && mem_valid)) wren_bad++;
      if (wren != 0) begin
        if (n_wr < N*N) begin wr_vec[n_wr] = wren; wr_addr[n_wr] = int'(mem_addr); end
        n_wr++; last_wr = i;
      end
      if (mac_clr) begin clr_n++; if (clr_first < 0) clr_first = i; end
      if (mac_en) begin
        if (run_start < 0) run_start = i;
        if (i - run_start < 16) begin
          rd_log[i - run_start] = rden; uf_log[i - run_start] = underflow;
        end
        run_len++; run_last = i;
      end
      for (int k = 0; k < N; k++) rd_cnt[k] += rden[k] ? 1 : 0;
      if (done) begin done_n++; done_cyc = i; end
      if (i == 1) uf_c1 = underflow;
      if (abort_cyc >= 0 && i == abort_cyc + 1)
        post_abort = {busy, mem_req, mac_clr, mac_en, |rden, |wren};
      if (abort_cyc >= 0 && i == abort_cyc + 2) clr2 = mac_clr;
      if (done_cyc >= 0 && i == done_cyc + 1) busy_after = busy;
      last_busy = busy; last_done = done;
      if (done_cyc >= 0 && i >= done_cyc + 2) begin finished = 1; break; end
      if (abort_cyc >= 0 && i >= abort_cyc + 3) begin finished = 1; break; end
    end
    start = 0; abort = 0; mem_valid = 0;
    timeout = !finished;
  endtask

  task automatic test_reset();
    rst = 1; mem_valid = 1;
    repeat (3) @(negedge clk);
    checks++; if ({mem_req, mac_en, mac_clr, busy, done, underflow} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_req, mac_en, mac_clr, busy, done, underflow}); end
    checks++; if (mem_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    checks++; if ({wren, rden} !== '0) begin
      errors++; $display("FAIL reset_en: got %b expected 0", {wren, rden}); end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++; if ({busy, mac_clr, mem_req, wren} !== '0) begin
      errors++; $display("FAIL idle_after_reset: got %b expected 0", {busy, mac_clr, mem_req, wren}); end
    mem_valid = 0;
  endtask

  task automatic check_run_profile(input string tag);
    for (int t = 0; t < RUNL; t++) begin
      logic [N-1:0] exp_rd;
      exp_rd = '0;
      for (int k = 0; k < N; k++) exp_rd[k] = (k <= t) && (t < k + N);
      checks++; if (rd_log[t] !== exp_rd) begin
        errors++; $display("FAIL %s_rden_t%0d: got %b expected %b", tag, t, rd_log[t], exp_rd); end
    end
    for (int k = 0; k < N; k++) begin
      checks++; if (rd_cnt[k] != N) begin
        errors++; $display("FAIL %s_rden_count%0d: got %0d expected %0d", tag, k, rd_cnt[k], N); end
    end
    checks++; if (run_len != RUNL || run_last - run_start + 1 != RUNL) begin
      errors++; $display("FAIL %s_mac_en_run: got %0d cycles span %0d expected %0d", tag, run_len, run_last - run_start + 1, RUNL); end
  endtask

  task automatic check_writes(input string tag);
    checks++; if (n_wr != N*N) begin
      errors++; $display("FAIL %s_write_count: got %0d expected %0d", tag, n_wr, N*N); end
    for (int j = 0; j < N*N; j++) begin
      logic [N-1:0] exp_w;
      exp_w = '0; exp_w[j / N] = 1'b1;
      checks++; if (wr_vec[j] !== exp_w || wr_addr[j] != j) begin
        errors++; $display("FAIL %s_write%0d: got wren %b addr %0d expected wren %b addr %0d", tag, j, wr_vec[j], wr_addr[j], exp_w, j); end
    end
    checks++; if (addr_bad != 0 || wren_bad != 0) begin
      errors++; $display("FAIL %s_addr_track: got %0d bad addrs %0d stray wren expected 0", tag, addr_bad, wren_bad); end
  endtask

  task automatic test_basic();
    run_tile(100, -1, 0);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: got timeout expected done"); end
    checks++; if (clr_n != 1 || clr_first != 1) begin
      errors++; $display("FAIL basic_clr: got %0d pulses first %0d expected 1 at 1", clr_n, clr_first); end
    check_writes("basic");
    check_run_profile("basic");
    checks++; if (last_wr != 1 + N*N || run_start != N*N + 3) begin
      errors++; $display("FAIL basic_timing: got last write %0d run %0d expected %0d %0d", last_wr, run_start, 1 + N*N, N*N + 3); end
    checks++; if (done_n != 1 || done_cyc != 1 + N*N + 1 + RUNL + 1) begin
      errors++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_n, done_cyc, 1 + N*N + 1 + RUNL + 1); end
    checks++; if (busy_after !== 0 || underflow !== 0) begin
      errors++; $display("FAIL basic_end: got busy %b uf %b expected 0 0", busy_after, underflow); end
  endtask

  task automatic test_stalls();
    run_tile(50, -1, 0);
    checks++; if (timeout) begin errors++; $display("FAIL stall_timeout: got timeout expected done"); end
    check_writes("stall");
    check_run_profile("stall");
    checks++; if (run_start != last_wr + 2 || done_cyc != last_wr + 2 + RUNL) begin
      errors++; $display("FAIL stall_timing: got run %0d done %0d expected %0d %0d", run_start, done_cyc, last_wr + 2, last_wr + 2 + RUNL); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL stall_done: got %0d expected 1", done_n); end
  endtask

  task automatic test_abort();
    run_tile(100, 7, 0);
    checks++; if (timeout || abort_cyc != 9) begin
      errors++; $display("FAIL abort_reach: got abort cycle %0d expected 9", abort_cyc); end
    checks++; if (post_abort !== 6'b001000) begin
      errors++; $display("FAIL abort_next: got %b expected 001000", post_abort); end
    checks++; if (clr2 !== 0 || clr_n != 2) begin
      errors++; $display("FAIL abort_clr: got next %b pulses %0d expected 0 2", clr2, clr_n); end
    checks++; if (done_n != 0 || run_len != 0) begin
      errors++; $display("FAIL abort_nodone: got done %0d run %0d expected 0 0", done_n, run_len); end
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    run_tile(100, -1, 0);
    checks++; if (timeout || wr_addr[0] != 0 || n_wr != N*N || done_n != 1) begin
      errors++; $display("FAIL abort_restart: got first addr %0d writes %0d done %0d expected 0 %0d 1", wr_addr[0], n_wr, done_n, N*N); end
  endtask

  task automatic test_underflow();
    force_empty = 4'b0100;
    run_tile(100, -1, 0);
    force_empty = '0;
    checks++; if (uf_log[2] !== 0 || uf_log[3] !== 1 || uf_log[RUNL-1] !== 1) begin
      errors++; $display("FAIL uf_set: got t2 %b t3 %b tlast %b expected 0 1 1", uf_log[2], uf_log[3], uf_log[RUNL-1]); end
    checks++; if (done_n != 1) begin errors++; $display("FAIL uf_done: got %0d expected 1", done_n); end
    repeat (3) @(negedge clk);
    checks++; if (underflow !== 1 || busy !== 0) begin
      errors++; $display("FAIL uf_hold: got uf %b busy %b expected 1 0", underflow, busy); end
    run_tile(100, -1, 0);
    checks++; if (uf_c1 !== 0 || underflow !== 0) begin
      errors++; $display("FAIL uf_clear: got c1 %b end %b expected 0 0", uf_c1, underflow); end
  endtask

  task automatic test_back_to_back();
    run_tile(70, -1, 1);
    checks++; if (timeout || done_n != 1 || clr_n != 1) begin
      errors++; $display("FAIL spam_single: got done %0d clr %0d expected 1 1", done_n, clr_n); end
    check_writes("spam");
    check_run_profile("spam");
    // a fresh start immediately after the previous tile is honoured
    run_tile(100, -1, 0);
    checks++; if (timeout || done_n != 1 || clr_first != 1) begin
      errors++; $display("FAIL b2b_restart: got done %0d clr at %0d expected 1 at 1", done_n, clr_first); end
  endtask

  task automatic test_async_reset();
    int t = 0;
    force_empty = 4'b1000;
    @(posedge clk); #1 start = 1; mem_valid = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mac_en) t++;
      if (t == 6) break;
    end
    checks++; if (t != 6 || underflow !== 1) begin
      errors++; $display("FAIL arst_prep: got run cycles %0d uf %b expected 6 1", t, underflow); end
    #1 rst = 1;
    #1;
    checks++; if ({mem_req, mac_en, mac_clr, busy, done, underflow, mem_addr, wren, rden} !== '0) begin
      errors++; $display("FAIL arst_outputs: got %b expected all 0", {mem_req, mac_en, mac_clr, busy, done, underflow, mem_addr, wren, rden}); end
    force_empty = '0;
    @(posedge clk); #1 rst = 0; mem_valid = 0;
    @(negedge clk);
    checks++; if (mac_clr !== 0 || busy !== 0) begin
      errors++; $display("FAIL arst_noclr: got clr %b busy %b expected 0 0", mac_clr, busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_abort();
    test_underflow();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
